seq_frame_tx: RTL and testbench



---
 rtl/seq_fsm_pkg.sv | 21 ++
 rtl/seq_frame_tx_if.sv | 22 ++
 rtl/seq_piso_shreg.sv | 32 +++
 rtl/seq_frame_tx.sv | 114 +++++++++++
 tb/tb_seq_frame_tx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the frame transmitter and the downstream sequence detector.
// The detector imports the same default sync pattern so both ends agree.
package seq_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;

  localparam logic [2:0] SYNC_PAT_DEFAULT = 3'b101;

  // Counter width covering the longer of the sync and payload sections, never zero.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// Word-in / serial-out bundle of the frame transmitter; master offers words, slave serialises.
// tx_valid/tx_ready handshake; out, busy and frame_done are status back to the master.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              out;
  logic              busy;
  logic              frame_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, out, busy, frame_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, out, busy, frame_done
  );
endinterface

// File: rtl/seq_piso_shreg.sv
// Parallel-load, MSB-first shift register with a running XOR of every bit shifted out.
// Load wins over shift; parity clears on load so it covers exactly the loaded word.
module seq_piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb,
  output logic         parity
);
  logic [W-1:0] sh_q;
  logic         par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      par_q <= 1'b0;
    end else if (load) begin
      sh_q  <= din;
      par_q <= 1'b0;
    end else if (shift) begin
      sh_q  <= sh_q << 1;
      par_q <= par_q ^ sh_q[W-1];
    end
  end

  assign msb    = sh_q[W-1];
  assign parity = par_q;
endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, payload MSB-first, optional even parity, idle 0.
// First bit on out right after the accept edge; ready in IDLE or while the last bit is out.
module seq_frame_tx
  import seq_fsm_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 3,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = SYNC_PAT_DEFAULT,
  parameter bit                PARITY_EN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  seq_frame_tx_if.slave bus
);
  localparam int            CW        = cnt_w(SYNC_W, DATA_W);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              done_q, done_d;
  logic              load, shift, eof;
  logic              sh_msb, sh_par;
  logic              last_bit, ready, accept;
  logic [SYNC_W-1:0] sync_rem;

  seq_piso_shreg #(.W(DATA_W)) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .din    (bus.tx_data),
    .msb    (sh_msb),
    .parity (sh_par)
  );

  assign last_bit = PARITY_EN ? (state_q == PAR)
                              : (state_q == DATA && cnt_q == DATA_LAST);
  assign ready    = (state_q == IDLE) || last_bit;
  assign accept   = bus.tx_valid && ready;
  // Remaining sync bits with the next one to send aligned at the MSB.
  assign sync_rem = SYNC_PAT << (cnt_q + 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    eof     = 1'b0;
    case (state_q)
      IDLE: ;
      SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          out_d   = sh_msb;
          shift   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          out_d = sync_rem[SYNC_W-1];
        end
      end
      DATA: begin
        if (cnt_q != DATA_LAST) begin
          cnt_d = cnt_q + 1'b1;
          out_d = sh_msb;
          shift = 1'b1;
        end else if (PARITY_EN) begin
          state_d = PAR;
          cnt_d   = '0;
          out_d   = sh_par;
        end else begin
          eof = 1'b1;
        end
      end
      PAR:     eof = 1'b1;
      default: state_d = IDLE;
    endcase
    if (eof) begin
      done_d  = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end
    // An accept on the last-bit cycle chains the next frame with no idle gap.
    if (accept) begin
      state_d = SYNC;
      cnt_d   = '0;
      out_d   = SYNC_PAT[SYNC_W-1];
      load    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_ready   = ready;
  assign bus.out        = out_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: directed frames, reset mid-frame, a narrow no-parity variant,
// and a random stream compared against a bit-queue model plus a 101 detector loopback.
module tb_seq_frame_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_frame_tx_if #(.DATA_W(8)) bus ();
  seq_frame_tx_if #(.DATA_W(4)) bus4 ();

  seq_frame_tx u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_frame_tx #(.DATA_W(4), .PARITY_EN(1'b0)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  typedef struct {
    bit b;
    bit last;
    bit sync_end;
  } mbit_t;

  mbit_t       mq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          det_cnt = 0;
  int          exp101 = 0;
  bit          h1 = 0, h2 = 0, e1 = 0, e2 = 0;
  logic [31:0] obs = '0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Frame as the wire sees it: sync 101, payload MSB first, even parity.
  task automatic push_frame(input logic [7:0] d);
    bit [2:0] sync_bits;
    int       ones;
    mbit_t    m;
    sync_bits = 3'b101;
    ones      = 0;
    for (int i = 0; i < 3; i++) begin
      m.b = sync_bits[2-i]; m.last = 1'b0; m.sync_end = (i == 2);
      mq.push_back(m);
    end
    for (int i = 7; i >= 0; i--) begin
      m.b = d[i]; m.last = 1'b0; m.sync_end = 1'b0;
      ones += int'(d[i]);
      mq.push_back(m);
    end
    m.b = bit'(ones % 2); m.last = 1'b1; m.sync_end = 1'b0;
    mq.push_back(m);
  endtask

  // One clock of the 8-bit DUT: drive, check ready before the edge, check outputs after it.
  task automatic cycle(input bit v, input logic [7:0] d);
    mbit_t popped;
    bit    had, exp_rdy, acc, exp_out, det;
    popped = '{b: 1'b0, last: 1'b0, sync_end: 1'b0};
    bus.tx_valid = v;
    bus.tx_data  = d;
    @(negedge clk);
    exp_rdy = (mq.size() <= 1);
    chk_eq("tx_ready", bus.tx_ready, exp_rdy);
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    had = (mq.size() > 0);
    if (had) popped = mq.pop_front();
    if (acc) push_frame(d);
    exp_out = (mq.size() > 0) ? mq[0].b : 1'b0;
    chk_eq("out", bus.out, exp_out);
    chk_eq("frame_done", bus.frame_done, had && popped.last);
    chk_eq("busy", bus.busy, mq.size() > 0);
    if (bus.frame_done === 1'b1) done_cnt++;
    obs = {obs[30:0], bus.out};
    det = h2 && !h1 && (bus.out === 1'b1);
    h2  = h1;
    h1  = (bus.out === 1'b1);
    if (det) det_cnt++;
    if (mq.size() > 0 && mq[0].sync_end) chk_eq("det_on_sync", det, 1);
    if (e2 && !e1 && exp_out) exp101++;
    e2 = e1;
    e1 = exp_out;
  endtask

  initial begin
    logic [6:0] exp7;
    rst           = 1'b1;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus4.tx_valid = 1'b0;
    bus4.tx_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_eq("rst_out", bus.out, 0);
    chk_eq("rst_done", bus.frame_done, 0);
    chk_eq("rst_busy", bus.busy, 0);
    chk_eq("rst_ready", bus.tx_ready, 1);
    @(posedge clk);
    #1;

    // Single 8'hA5 frame.
    cycle(1'b1, 8'hA5);
    repeat (11) cycle(1'b0, 8'h00);
    chk_eq("a5_stream", obs[11:0], 12'hB4A);
    done_cnt = 0;
    repeat (3) cycle(1'b0, 8'h00);
    chk_eq("a5_done_cnt", done_cnt, 1);

    // Back-to-back 8'hFF then 8'h01, second accepted in the parity cycle.
    done_cnt = 0;
    cycle(1'b1, 8'hFF);
    repeat (12) cycle(1'b1, 8'h01);
    repeat (11) cycle(1'b0, 8'h00);
    chk_eq("b2b_stream", obs[23:0], 24'hBFEA03);
    repeat (3) cycle(1'b0, 8'h00);
    chk_eq("b2b_done_cnt", done_cnt, 2);

    // Valid held with changing data while busy.
    done_cnt = 0;
    cycle(1'b1, 8'h3C);
    repeat (10) cycle(1'b1, 8'hC3);
    cycle(1'b0, 8'h00);
    chk_eq("hold_stream", obs[11:0], 12'hA78);
    repeat (14) cycle(1'b0, 8'h00);
    chk_eq("hold_done_cnt", done_cnt, 1);

    // Reset while the 6th bit of an 8'hAA frame is on out.
    done_cnt = 0;
    cycle(1'b1, 8'hAA);
    repeat (5) cycle(1'b0, 8'h00);
    chk_eq("aa_bit5", bus.out, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_out", bus.out, 0);
    chk_eq("arst_busy", bus.busy, 0);
    chk_eq("arst_done", bus.frame_done, 0);
    mq.delete();
    h1 = 0; h2 = 0; e1 = 0; e2 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_eq("post_rst_ready", bus.tx_ready, 1);
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h01);
    repeat (11) cycle(1'b0, 8'h00);
    chk_eq("post_rst_stream", obs[11:0], 12'hA03);
    repeat (2) cycle(1'b0, 8'h00);
    chk_eq("post_rst_done_cnt", done_cnt, 1);

    // Narrow variant: DATA_W=4, no parity, 4'b1001.
    exp7 = 7'b1011001;
    bus4.tx_valid = 1'b1;
    bus4.tx_data  = 4'b1001;
    @(negedge clk);
    chk_eq("w4_ready", bus4.tx_ready, 1);
    @(posedge clk);
    #1;
    bus4.tx_valid = 1'b0;
    bus4.tx_data  = 4'b0110;
    for (int i = 0; i < 7; i++) begin
      chk_eq("w4_out", bus4.out, exp7[6-i]);
      chk_eq("w4_done", bus4.frame_done, 0);
      @(posedge clk);
      #1;
    end
    chk_eq("w4_idle_out", bus4.out, 0);
    chk_eq("w4_done_pulse", bus4.frame_done, 1);
    chk_eq("w4_busy", bus4.busy, 0);
    @(posedge clk);
    #1;
    chk_eq("w4_done_clear", bus4.frame_done, 0);

    // Random traffic with embedded 101 patterns in payloads.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom));
    end
    repeat (20) cycle(1'b0, 8'h00);
    chk_eq("det_total", det_cnt, exp101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
